// File: rtl/perf_counter_pkg.sv
// Shared constants, access-decode types and the address decode helper for the
// performance counter controller.
package perf_counter_pkg;

   localparam int AddrWidth   = 5;
   localparam int MaxCounters = 15;

   localparam logic [AddrWidth-1:0] AddrInhibit = 5'd30;
   localparam logic [AddrWidth-1:0] AddrOvf     = 5'd31;

   // Kind of register touched by one bus access.
   typedef enum logic [2:0] {
      ACC_CNT_LO  = 3'd0,
      ACC_CNT_HI  = 3'd1,
      ACC_INHIBIT = 3'd2,
      ACC_OVF     = 3'd3,
      ACC_ERR     = 3'd4
   } acc_kind_e;

   typedef struct packed {
      acc_kind_e  kind;
      logic [3:0] idx;
   } acc_dec_t;

   // Map a word index onto a register kind plus counter index: the upper
   // address bits select the counter and bit 0 selects its half; indices
   // outside the implemented range decode as errors.
   function automatic acc_dec_t decode_addr(input logic [AddrWidth-1:0] addr,
                                            input logic [3:0]           num_cnt);
      acc_dec_t dec;
      dec.idx = addr[AddrWidth-1:1];
      if (addr == AddrInhibit) begin
         dec.kind = ACC_INHIBIT;
      end else if (addr == AddrOvf) begin
         dec.kind = ACC_OVF;
      end else if (addr[AddrWidth-1:1] < num_cnt) begin
         dec.kind = addr[0] ? ACC_CNT_HI : ACC_CNT_LO;
      end else begin
         dec.kind = ACC_ERR;
      end
      return dec;
   endfunction

endpackage

// File: rtl/perf_counter_shadow.sv
// High-word shadow: a low-word read snapshots the upper half of the same
// counter so the following high-word read returns a coherent 64-bit value
// even if the counter carried in between.
module perf_counter_shadow
   import perf_counter_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        rd_lo,
   input  logic        rd_hi,
   input  logic        wr_cnt,
   input  logic [3:0]  idx,
   input  logic [31:0] live_hi,
   output logic [31:0] hi_data
);

   logic        shadow_valid_r;
   logic [3:0]  shadow_idx_r;
   logic [31:0] shadow_hi_r;
   logic        hit_s;

   // Shadow applies only to the counter it was captured from.
   always_comb begin
      hit_s   = shadow_valid_r & (shadow_idx_r == idx);
      hi_data = hit_s ? shadow_hi_r : live_hi;
   end

   // Capture on low read; consume on matching high read; drop on any write
   // to the shadowed counter so stale data is never returned.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shadow_valid_r <= 1'b0;
         shadow_idx_r   <= 4'd0;
         shadow_hi_r    <= 32'd0;
      end else if (rd_lo) begin
         shadow_valid_r <= 1'b1;
         shadow_idx_r   <= idx;
         shadow_hi_r    <= live_hi;
      end else if ((rd_hi | wr_cnt) & hit_s) begin
         shadow_valid_r <= 1'b0;
      end else begin
         shadow_valid_r <= shadow_valid_r;
      end
   end

endmodule

// File: rtl/perf_counter_ctrl.sv
// Register-access and sequencing controller for a bank of 64-bit performance
// counters: bus decode, write strobes, gated increments, coherent reads,
// count inhibit and sticky overflow with interrupt.
module perf_counter_ctrl
   import perf_counter_pkg::*;
#(
   parameter int NumCounters  = 4,
   parameter int CounterWidth = 64
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      req_i,
   input  logic                      we_i,
   input  logic [AddrWidth-1:0]      addr_i,
   input  logic [31:0]               wdata_i,
   output logic                      rvalid_o,
   output logic [31:0]               rdata_o,
   output logic                      err_o,
   input  logic [NumCounters-1:0]    events_i,
   input  logic [64*NumCounters-1:0] counter_val_i,
   output logic [NumCounters-1:0]    counter_inc_o,
   output logic [NumCounters-1:0]    counter_we_o,
   output logic [NumCounters-1:0]    counterh_we_o,
   output logic [31:0]               counter_wdata_o,
   output logic                      irq_o
);

   localparam logic [3:0]  NumCntL = 4'(NumCounters);
   // Bits of the counter that are implemented; all-ones here means wrap next.
   localparam logic [63:0] CntMask = {64{1'b1}} >> (64 - CounterWidth);

   acc_dec_t               dec_s;
   logic                   wr_s;
   logic                   rd_s;
   logic [31:0]            sel_lo_s;
   logic [31:0]            sel_hi_s;
   logic [31:0]            shadow_rdata_s;
   logic [31:0]            rd_data_s;
   logic [NumCounters-1:0] cnt_full_s;
   logic [NumCounters-1:0] ovf_set_s;
   logic [NumCounters-1:0] ovf_clr_s;
   logic [NumCounters-1:0] ovf_nxt_s;
   logic [NumCounters-1:0] inhibit_r;
   logic [NumCounters-1:0] ovf_r;

   // Decode the access; error accesses are neither reads nor writes.
   always_comb begin
      dec_s = decode_addr(addr_i, NumCntL);
      wr_s  = req_i &  we_i & (dec_s.kind != ACC_ERR);
      rd_s  = req_i & ~we_i & (dec_s.kind != ACC_ERR);
   end

   // Per-counter write strobes, shared write data and gated increments.
   always_comb begin
      counter_we_o    = '0;
      counterh_we_o   = '0;
      counter_wdata_o = wdata_i;
      counter_inc_o   = events_i & ~inhibit_r;
      for (int k = 0; k < NumCounters; k++) begin
         counter_we_o[k]  = wr_s & (dec_s.kind == ACC_CNT_LO) & (dec_s.idx == 4'(k));
         counterh_we_o[k] = wr_s & (dec_s.kind == ACC_CNT_HI) & (dec_s.idx == 4'(k));
      end
   end

   // Select the low and high words of the addressed counter.
   always_comb begin
      sel_lo_s = 32'd0;
      sel_hi_s = 32'd0;
      for (int k = 0; k < NumCounters; k++) begin
         sel_lo_s = sel_lo_s | ({32{dec_s.idx == 4'(k)}} & counter_val_i[64*k +: 32]);
         sel_hi_s = sel_hi_s | ({32{dec_s.idx == 4'(k)}} & counter_val_i[64*k+32 +: 32]);
      end
   end

   // Overflow set/clear; a set in the same cycle as a clear wins. A counter
   // being written this cycle takes its write instead of incrementing.
   always_comb begin
      cnt_full_s = '0;
      for (int k = 0; k < NumCounters; k++) begin
         cnt_full_s[k] = ((counter_val_i[64*k +: 64] & CntMask) == CntMask);
      end
      ovf_set_s = counter_inc_o & ~counter_we_o & ~counterh_we_o & cnt_full_s;
      ovf_clr_s = (wr_s && (dec_s.kind == ACC_OVF)) ? wdata_i[NumCounters-1:0] : '0;
      ovf_nxt_s = (ovf_r & ~ovf_clr_s) | ovf_set_s;
   end

   perf_counter_shadow u_shadow (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .rd_lo   (rd_s & (dec_s.kind == ACC_CNT_LO)),
      .rd_hi   (rd_s & (dec_s.kind == ACC_CNT_HI)),
      .wr_cnt  (wr_s & ((dec_s.kind == ACC_CNT_LO) | (dec_s.kind == ACC_CNT_HI))),
      .idx     (dec_s.idx),
      .live_hi (sel_hi_s),
      .hi_data (shadow_rdata_s)
   );

   // Read data multiplexer for the addressed register.
   always_comb begin
      rd_data_s = 32'd0;
      case (dec_s.kind)
         ACC_CNT_LO:  rd_data_s = sel_lo_s;
         ACC_CNT_HI:  rd_data_s = shadow_rdata_s;
         ACC_INHIBIT: rd_data_s = 32'(inhibit_r);
         ACC_OVF:     rd_data_s = 32'(ovf_r);
         default:     rd_data_s = 32'd0;
      endcase
   end

   // One-cycle registered response; data only for successful reads.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_o <= 1'b0;
         rdata_o  <= 32'd0;
         err_o    <= 1'b0;
      end else begin
         rvalid_o <= req_i;
         err_o    <= req_i & (dec_s.kind == ACC_ERR);
         rdata_o  <= rd_s ? rd_data_s : 32'd0;
      end
   end

   // Control state: inhibit mask, sticky overflow flags and interrupt.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inhibit_r <= '0;
         ovf_r     <= '0;
         irq_o     <= 1'b0;
      end else begin
         if (wr_s && (dec_s.kind == ACC_INHIBIT)) begin
            inhibit_r <= wdata_i[NumCounters-1:0];
         end else begin
            inhibit_r <= inhibit_r;
         end
         ovf_r <= ovf_nxt_s;
         irq_o <= |ovf_nxt_s;
      end
   end

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Self-checking bench for perf_counter_ctrl: directed vector table, hand
// sequences for shadow/overflow/reset corners, and randomized traffic checked
// against a behavioural model. The bench also plays the counter instances.
module tb_perf_counter_ctrl;

   localparam int N = 4;

   logic            clk;
   logic            rst_n;
   logic            req;
   logic            we;
   logic [4:0]      addr;
   logic [31:0]     wdata;
   logic            rvalid;
   logic [31:0]     rdata;
   logic            err;
   logic [N-1:0]    events;
   logic [N-1:0][63:0] cnt;
   logic [N-1:0]    inc;
   logic [N-1:0]    cwe;
   logic [N-1:0]    chwe;
   logic [31:0]     cwdata;
   logic            irq;

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural model state
   logic [N-1:0] m_inh;
   logic [N-1:0] m_ovf;
   logic         m_sv;
   int           m_sidx;
   logic [31:0]  m_shi;

   // combinational outputs sampled during the last cycle
   logic [N-1:0] s_inc;
   logic [N-1:0] s_we;
   logic [N-1:0] s_hwe;

   perf_counter_ctrl #(.NumCounters(N), .CounterWidth(64)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .req_i           (req),
      .we_i            (we),
      .addr_i          (addr),
      .wdata_i         (wdata),
      .rvalid_o        (rvalid),
      .rdata_o         (rdata),
      .err_o           (err),
      .events_i        (events),
      .counter_val_i   (cnt),
      .counter_inc_o   (inc),
      .counter_we_o    (cwe),
      .counterh_we_o   (chwe),
      .counter_wdata_o (cwdata),
      .irq_o           (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_inh  = '0;
      m_ovf  = '0;
      m_sv   = 1'b0;
      m_sidx = 0;
      m_shi  = 32'd0;
   endtask

   // One bus cycle, entered at posedge+1. Checks combinational outputs
   // mid-cycle and the registered response after the edge against the model.
   task automatic cycle(input logic r, input logic w, input logic [4:0] a,
                        input logic [31:0] d, input logic [N-1:0] ev);
      logic [N-1:0] x_we, x_hwe, x_inc, set, clr;
      logic [31:0]  e_rdata;
      logic         is_err, is_hi, e_irq;
      int           k;
      req = r; we = w; addr = a; wdata = d; events = ev;
      k      = int'(a) / 2;
      is_hi  = a[0];
      is_err = !((a == 5'd30) || (a == 5'd31) || (k < N));
      x_we   = '0;
      x_hwe  = '0;
      if (r && w && !is_err && a < 5'd30) begin
         if (is_hi) x_hwe[k] = 1'b1;
         else       x_we[k]  = 1'b1;
      end
      x_inc = ev & ~m_inh;
      #3;
      s_inc = inc; s_we = cwe; s_hwe = chwe;
      chk("inc", inc, x_inc);
      chk("we_lo", cwe, x_we);
      chk("we_hi", chwe, x_hwe);
      chk("wdata", cwdata, d);
      // read data from pre-edge state
      e_rdata = 32'd0;
      if (r && !w && !is_err) begin
         if (a == 5'd30)      e_rdata = 32'(m_inh);
         else if (a == 5'd31) e_rdata = 32'(m_ovf);
         else if (!is_hi) begin
            e_rdata = cnt[k][31:0];
            m_sv = 1'b1; m_sidx = k; m_shi = cnt[k][63:32];
         end else if (m_sv && m_sidx == k) begin
            e_rdata = m_shi;
            m_sv = 1'b0;
         end else begin
            e_rdata = cnt[k][63:32];
         end
      end
      if (r && w && !is_err) begin
         if (a == 5'd30) m_inh = d[N-1:0];
         else if (a < 5'd30 && m_sv && m_sidx == k) m_sv = 1'b0;
      end
      for (int j = 0; j < N; j++)
         set[j] = x_inc[j] & ~x_we[j] & ~x_hwe[j] & (cnt[j] == 64'hFFFF_FFFF_FFFF_FFFF);
      clr   = (r && w && a == 5'd31) ? d[N-1:0] : '0;
      m_ovf = (m_ovf & ~clr) | set;
      e_irq = |m_ovf;
      @(posedge clk);
      #1;
      for (int j = 0; j < N; j++) begin
         if (x_we[j])       cnt[j][31:0]  = d;
         else if (x_hwe[j]) cnt[j][63:32] = d;
         else if (x_inc[j]) cnt[j]        = cnt[j] + 64'd1;
      end
      chk("rvalid", rvalid, r);
      chk("err", err, r && is_err);
      chk("rdata", rdata, e_rdata);
      chk("irq", irq, e_irq);
   endtask

   typedef struct {
      logic         r;
      logic         w;
      logic [4:0]   a;
      logic [31:0]  d;
      logic [N-1:0] ev;
      logic [N-1:0] x_we;
      logic [N-1:0] x_hwe;
      logic [N-1:0] x_inc;
      logic [31:0]  x_rdata;
      logic         x_err;
   } vec_t;

   vec_t vt[12];

   initial begin
      // r w  addr   wdata         ev       we       hwe      inc      rdata         err
      vt[0]  = '{1'b1, 1'b0, 5'd30, 32'h0,        4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0,        1'b0};
      vt[1]  = '{1'b1, 1'b0, 5'd31, 32'h0,        4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0,        1'b0};
      vt[2]  = '{1'b1, 1'b1, 5'd2,  32'hDEADBEEF, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 32'h0,        1'b0};
      vt[3]  = '{1'b1, 1'b1, 5'd3,  32'h12345678, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 32'h0,        1'b0};
      vt[4]  = '{1'b1, 1'b0, 5'd20, 32'h0,        4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0,        1'b1};
      vt[5]  = '{1'b1, 1'b1, 5'd20, 32'hFFFFFFFF, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0,        1'b1};
      vt[6]  = '{1'b1, 1'b1, 5'd30, 32'h2,        4'b1111, 4'b0000, 4'b0000, 4'b1111, 32'h0,        1'b0};
      vt[7]  = '{1'b1, 1'b0, 5'd30, 32'h0,        4'b1111, 4'b0000, 4'b0000, 4'b1101, 32'h2,        1'b0};
      vt[8]  = '{1'b1, 1'b1, 5'd30, 32'h0,        4'b1111, 4'b0000, 4'b0000, 4'b1101, 32'h0,        1'b0};
      vt[9]  = '{1'b1, 1'b0, 5'd30, 32'h0,        4'b1111, 4'b0000, 4'b0000, 4'b1111, 32'h0,        1'b0};
      vt[10] = '{1'b1, 1'b0, 5'd2,  32'h0,        4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'hDEADBEF1, 1'b0};
      vt[11] = '{1'b1, 1'b0, 5'd3,  32'h0,        4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h12345678, 1'b0};

      rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 5'd0; wdata = 32'd0;
      events = '0; cnt = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_rvalid", rvalid, 1'b0);
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_err", err, 1'b0);
      chk("reset_irq", irq, 1'b0);

      // directed vector table
      for (int i = 0; i < 12; i++) begin
         cycle(vt[i].r, vt[i].w, vt[i].a, vt[i].d, vt[i].ev);
         chk($sformatf("vec%0d_we", i), s_we, vt[i].x_we);
         chk($sformatf("vec%0d_hwe", i), s_hwe, vt[i].x_hwe);
         chk($sformatf("vec%0d_inc", i), s_inc, vt[i].x_inc);
         chk($sformatf("vec%0d_rdata", i), rdata, vt[i].x_rdata);
         chk($sformatf("vec%0d_err", i), err, vt[i].x_err);
      end

      // coherent 64-bit read across a carry
      cnt[0] = 64'h0000_0001_FFFF_FFFF;
      cycle(1'b1, 1'b0, 5'd0, 32'd0, 4'b0001);
      chk("shadow_lo", rdata, 32'hFFFFFFFF);
      cycle(1'b1, 1'b0, 5'd1, 32'd0, 4'b0000);
      chk("shadow_hi", rdata, 32'h00000001);
      cycle(1'b1, 1'b0, 5'd1, 32'd0, 4'b0000);
      chk("live_hi", rdata, 32'h00000002);
      // a write to the shadowed counter drops the snapshot
      cycle(1'b1, 1'b0, 5'd0, 32'd0, 4'b0000);
      cycle(1'b1, 1'b1, 5'd1, 32'h9, 4'b0000);
      cycle(1'b1, 1'b0, 5'd1, 32'd0, 4'b0000);
      chk("shadow_drop", rdata, 32'h9);

      // overflow set, W1C clear, set-beats-clear, write suppresses set
      cnt[2] = 64'hFFFF_FFFF_FFFF_FFFF;
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 4'b0100);
      chk("ovf_irq_set", irq, 1'b1);
      cycle(1'b1, 1'b0, 5'd31, 32'd0, 4'b0000);
      chk("ovf_read", rdata, 32'h4);
      cycle(1'b1, 1'b1, 5'd31, 32'h4, 4'b0000);
      chk("ovf_irq_clr", irq, 1'b0);
      cnt[2] = 64'hFFFF_FFFF_FFFF_FFFF;
      cycle(1'b1, 1'b1, 5'd31, 32'h4, 4'b0100);
      chk("ovf_set_wins", irq, 1'b1);
      cnt[1] = 64'hFFFF_FFFF_FFFF_FFFF;
      cycle(1'b1, 1'b1, 5'd2, 32'h0, 4'b0010);
      cycle(1'b1, 1'b0, 5'd31, 32'd0, 4'b0000);
      chk("ovf_write_supp", rdata, 32'h4);
      cycle(1'b1, 1'b1, 5'd31, 32'hF, 4'b0000);
      chk("ovf_all_clr", irq, 1'b0);

      // reset in the middle of an access
      cycle(1'b1, 1'b1, 5'd30, 32'h5, 4'b0000);
      cnt[3] = 64'hFFFF_FFFF_FFFF_FFFF;
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 4'b1000);
      req = 1'b1; we = 1'b0; addr = 5'd31; events = '0;
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_mid_rvalid", rvalid, 1'b0);
      chk("rst_mid_irq", irq, 1'b0);
      req = 1'b0;
      #2 rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      cycle(1'b1, 1'b0, 5'd30, 32'd0, 4'b0000);
      chk("rst_inhibit", rdata, 32'h0);
      cycle(1'b1, 1'b0, 5'd31, 32'd0, 4'b0000);
      chk("rst_ovf", rdata, 32'h0);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            int j;
            j = $urandom_range(0, N - 1);
            if ($urandom_range(0, 1) == 0) cnt[j] = 64'hFFFF_FFFF_FFFF_FFFF;
            else cnt[j] = {32'($urandom), 32'hFFFF_FFFF};
         end
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
               5'($urandom_range(0, 31)), 32'($urandom), N'($urandom));
      end

      req = 1'b0; we = 1'b0; events = '0;
      @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
